// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed multiply/divide engine (MULT, DIV) producing HI/LO
//
// Ports:
//   clock      in   1      system clock, rising edge
//   reset      in   1      synchronous, active-high
//   MDcontrol  in   2      00 none, 01 MULT, 10 DIV, 11 none
//   a_in       in   WIDTH  multiplicand / dividend
//   b_in       in   WIDTH  multiplier / divisor
//   hi_out     out  WIDTH  MULT: product upper half; DIV: remainder
//   lo_out     out  WIDTH  MULT: product lower half; DIV: quotient
//   md_busy    out  1      operation in progress
//   md_done    out  1      one-cycle pulse, hi_out/lo_out valid
//   Div0       out  1      one-cycle pulse on DIV with zero divisor
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       MDcontrol,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             md_busy,
    output logic             md_done,
    output logic             Div0
);

    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

    localparam logic [1:0]       OP_MULT = 2'b01;
    localparam logic [1:0]       OP_DIV  = 2'b10;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    // p/q double as Booth {P, Q} and as remainder / shifting dividend-quotient.
    logic [WIDTH-1:0] p_q, p_d, q_q, q_d, m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             qm1_q, qm1_d, qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   booth_sum, div_shift, div_diff;
    logic             last_step;

    assign a_abs     = a_in[WIDTH-1] ? -a_in : a_in;
    assign b_abs     = b_in[WIDTH-1] ? -b_in : b_in;
    assign last_step = (cnt_q == LAST);

    // One extra bit so P - M cannot overflow when M is the most negative value.
    always_comb begin
        booth_sum = {p_q[WIDTH-1], p_q};
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum = {p_q[WIDTH-1], p_q} + {m_q[WIDTH-1], m_q};
            2'b10:   booth_sum = {p_q[WIDTH-1], p_q} - {m_q[WIDTH-1], m_q};
            default: booth_sum = {p_q[WIDTH-1], p_q};
        endcase
    end

    // Partial remainder stays below the divisor (<= 2^(WIDTH-1)), so the
    // shifted value minus divisor always fits and its top bit is the borrow.
    assign div_shift = {p_q, q_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (MDcontrol == OP_MULT)
                    state_d = S_MULT;
                else if (MDcontrol == OP_DIV && b_in != '0)
                    state_d = S_DIV;
            end
            S_MULT:  if (last_step) state_d = S_DONE;
            S_DIV:   if (last_step) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        p_d    = p_q;
        q_d    = q_q;
        m_d    = m_q;
        qm1_d  = qm1_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        div0_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MDcontrol == OP_MULT) begin
                    p_d   = '0;
                    q_d   = b_in;
                    m_d   = a_in;
                    qm1_d = 1'b0;
                    cnt_d = '0;
                end else if (MDcontrol == OP_DIV) begin
                    if (b_in == '0) begin
                        div0_d = 1'b1;
                    end else begin
                        p_d    = '0;
                        q_d    = a_abs;
                        m_d    = b_abs;
                        qneg_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        rneg_d = a_in[WIDTH-1];
                        cnt_d  = '0;
                    end
                end
            end
            S_MULT: begin
                p_d   = booth_sum[WIDTH:1];
                q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    hi_d = booth_sum[WIDTH:1];
                    lo_d = {booth_sum[0], q_q[WIDTH-1:1]};
                end
            end
            S_DIV: begin
                if (!div_diff[WIDTH]) begin
                    p_d = div_diff[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    p_d = div_shift[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
            end
            S_FIX: begin
                lo_d = qneg_q ? -q_q : q_q;
                hi_d = rneg_q ? -p_q : p_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div0_q  <= div0_d;
        end
    end

    assign hi_out  = hi_q;
    assign lo_out  = lo_q;
    assign Div0    = div0_q;
    assign md_busy = (state_q != S_IDLE);
    assign md_done = (state_q == S_DONE);

endmodule
